// File: rtl/memory_write_ctrl_if.sv
// Ingress, free-list, memory-write and packet-completion signals of memory_write_ctrl.
// slave is the controller side; master is the side that drives ingress and free-list.
interface memory_write_ctrl_if #(
  parameter int ADDR_W     = 12,
  parameter int BLOCK_BITS = 512,
  parameter int LEN_W      = 8
) ();
  logic                  data_valid_i;
  logic [BLOCK_BITS-1:0] data_i;
  logic                  data_end_i;
  logic                  data_ready_o;
  logic                  alloc_valid_i;
  logic [ADDR_W-1:0]     alloc_idx_i;
  logic                  alloc_ready_o;
  logic                  mem_we_o;
  logic [ADDR_W-1:0]     mem_waddr_o;
  logic [BLOCK_BITS-1:0] mem_wdata_o;
  logic                  pkt_done_o;
  logic [ADDR_W-1:0]     pkt_head_o;
  logic [LEN_W-1:0]      pkt_len_o;

  modport slave (
    input  data_valid_i, data_i, data_end_i, alloc_valid_i, alloc_idx_i,
    output data_ready_o, alloc_ready_o, mem_we_o, mem_waddr_o, mem_wdata_o,
           pkt_done_o, pkt_head_o, pkt_len_o
  );

  modport master (
    output data_valid_i, data_i, data_end_i, alloc_valid_i, alloc_idx_i,
    input  data_ready_o, alloc_ready_o, mem_we_o, mem_waddr_o, mem_wdata_o,
           pkt_done_o, pkt_head_o, pkt_len_o
  );
endinterface

// File: rtl/memory_write_ctrl.sv
// Writes packet blocks into free-list-allocated memory blocks, chaining them through a 16-bit footer.
// Footer layout: [ADDR_W-1:0] next_idx, [15] eop, remaining bits reserved as 0 (ADDR_W <= 15).
module memory_write_ctrl #(
  parameter int ADDR_W     = 12,
  parameter int BLOCK_BITS = 512,
  parameter int LEN_W      = 8
) (
  input logic                clk,
  input logic                rst_n,
  memory_write_ctrl_if.slave bus
);

  typedef enum logic {IDLE, IN_PKT} state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_cur, r_nxt;
  logic              r_cur_v, r_nxt_v;
  logic [ADDR_W-1:0] r_acc_head, w_acc_head;
  logic [LEN_W-1:0]  r_acc_len, w_acc_len, w_len_inc;
  logic              r_we, r_done, w_done;
  logic [ADDR_W-1:0] r_waddr, r_pkt_head, w_pkt_head;
  logic [BLOCK_BITS-1:0] r_wdata;
  logic [LEN_W-1:0]  r_pkt_len, w_pkt_len;
  logic [15:0]       w_footer;
  logic              w_data_fire, w_alloc_fire;
  logic              w_unused_footer_slot;

  // Incoming footer slot is overwritten by the generated footer.
  assign w_unused_footer_slot = ^bus.data_i[15:0];

  // Ready strobes come only from slot state, so the two handshakes are mutually exclusive.
  assign bus.data_ready_o  = r_cur_v && r_nxt_v;
  assign bus.alloc_ready_o = !(r_cur_v && r_nxt_v);
  assign w_data_fire       = bus.data_valid_i && bus.data_ready_o;
  assign w_alloc_fire      = bus.alloc_valid_i && bus.alloc_ready_o;

  assign bus.mem_we_o    = r_we;
  assign bus.mem_waddr_o = r_waddr;
  assign bus.mem_wdata_o = r_wdata;
  assign bus.pkt_done_o  = r_done;
  assign bus.pkt_head_o  = r_pkt_head;
  assign bus.pkt_len_o   = r_pkt_len;

  always_comb begin
    w_footer = '0;
    if (bus.data_end_i) begin
      w_footer[15] = 1'b1;
    end else begin
      w_footer[ADDR_W-1:0] = r_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_data_fire) begin
      w_state_nxt = bus.data_end_i ? IDLE : IN_PKT;
    end
  end

  assign w_len_inc = (r_acc_len == '1) ? r_acc_len : r_acc_len + LEN_W'(1);

  always_comb begin
    w_acc_head = r_acc_head;
    w_acc_len  = r_acc_len;
    w_done     = 1'b0;
    w_pkt_head = r_pkt_head;
    w_pkt_len  = r_pkt_len;
    if (w_data_fire) begin
      case (r_state)
        IDLE: begin
          w_acc_head = r_cur;
          w_acc_len  = LEN_W'(1);
        end
        IN_PKT: w_acc_len = w_len_inc;
        default: ;
      endcase
      if (bus.data_end_i) begin
        w_done     = 1'b1;
        w_pkt_head = w_acc_head;
        w_pkt_len  = w_acc_len;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cur      <= '0;
      r_nxt      <= '0;
      r_cur_v    <= 1'b0;
      r_nxt_v    <= 1'b0;
      r_we       <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
      r_done     <= 1'b0;
      r_acc_head <= '0;
      r_acc_len  <= '0;
      r_pkt_head <= '0;
      r_pkt_len  <= '0;
    end else begin
      r_we       <= w_data_fire;
      r_done     <= w_done;
      r_acc_head <= w_acc_head;
      r_acc_len  <= w_acc_len;
      r_pkt_head <= w_pkt_head;
      r_pkt_len  <= w_pkt_len;
      if (w_data_fire) begin
        r_waddr <= r_cur;
        r_wdata <= {bus.data_i[BLOCK_BITS-1:16], w_footer};
        r_cur   <= r_nxt;
        r_nxt_v <= 1'b0;
      end else if (w_alloc_fire) begin
        if (!r_cur_v) begin
          r_cur   <= bus.alloc_idx_i;
          r_cur_v <= 1'b1;
        end else begin
          r_nxt   <= bus.alloc_idx_i;
          r_nxt_v <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_memory_write_ctrl.sv
// Scoreboard bench for memory_write_ctrl: a default instance plus a LEN_W=2 instance fed the same inputs.
module tb_memory_write_ctrl;
  localparam int AW = 12;
  localparam int BB = 512;
  localparam int LW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  memory_write_ctrl_if #(.ADDR_W(AW), .BLOCK_BITS(BB), .LEN_W(LW)) bus ();
  memory_write_ctrl_if #(.ADDR_W(AW), .BLOCK_BITS(BB), .LEN_W(2))  bus2 ();

  assign bus2.data_valid_i  = bus.data_valid_i;
  assign bus2.data_i        = bus.data_i;
  assign bus2.data_end_i    = bus.data_end_i;
  assign bus2.alloc_valid_i = bus.alloc_valid_i;
  assign bus2.alloc_idx_i   = bus.alloc_idx_i;

  memory_write_ctrl #(.ADDR_W(AW), .BLOCK_BITS(BB), .LEN_W(LW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  memory_write_ctrl #(.ADDR_W(AW), .BLOCK_BITS(BB), .LEN_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .bus(bus2)
  );

  typedef struct {logic [AW-1:0] addr; logic [BB-1:0] data;} wr_t;
  typedef struct {logic [AW-1:0] head; int unsigned len;} done_t;
  typedef struct {logic [BB-1:0] data; logic last;} blk_t;

  wr_t   wr_q[$];
  done_t done_q[$];
  blk_t  blk_q[$];
  logic [AW-1:0] fl_q[$];
  logic [AW-1:0] held[$];

  int checks = 0;
  int errors = 0;
  logic alloc_on;
  logic in_pkt;
  logic [AW-1:0] p_head;
  int unsigned p_len;
  logic [AW-1:0] last_head;
  int unsigned last_len;
  wr_t   mw;
  done_t md;

  task automatic check(input string tag, input logic [BB-1:0] got, input logic [BB-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [BB-1:0] rnd_block();
    logic [BB-1:0] r;
    for (int i = 0; i < BB / 32; i++) r[i*32 +: 32] = $urandom;
    r[15:0] = 16'hFFFF;
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.mem_we_o) begin
        if (wr_q.size() == 0) begin
          check("spurious_we", 1'b1, 1'b0);
        end else begin
          mw = wr_q.pop_front();
          check("waddr", bus.mem_waddr_o, mw.addr);
          check("wdata", bus.mem_wdata_o, mw.data);
          check("wdata_sat", bus2.mem_wdata_o, mw.data);
        end
      end
      if (bus.pkt_done_o) begin
        if (done_q.size() == 0) begin
          check("spurious_done", 1'b1, 1'b0);
        end else begin
          md = done_q.pop_front();
          check("done_with_we", bus.mem_we_o, 1'b1);
          check("pkt_head", bus.pkt_head_o, md.head);
          check("pkt_len", bus.pkt_len_o, md.len);
          check("done_sat", bus2.pkt_done_o, 1'b1);
          check("pkt_len_sat", bus2.pkt_len_o, (md.len > 3) ? 3 : md.len);
          last_head = md.head;
          last_len  = md.len;
        end
      end else begin
        check("head_hold", bus.pkt_head_o, last_head);
        check("len_hold", bus.pkt_len_o, last_len);
      end
    end
  end

  task automatic step();
    blk_t b;
    logic [AW-1:0] addr;
    logic [15:0] foot;
    @(negedge clk);
    bus.alloc_valid_i = alloc_on && (fl_q.size() > 0);
    bus.alloc_idx_i   = (fl_q.size() > 0) ? fl_q[0] : '0;
    bus.data_valid_i  = (blk_q.size() > 0);
    bus.data_i        = (blk_q.size() > 0) ? blk_q[0].data : '0;
    bus.data_end_i    = (blk_q.size() > 0) ? blk_q[0].last : 1'b0;
    #1;
    check("data_ready", bus.data_ready_o, held.size() >= 2);
    check("alloc_ready", bus.alloc_ready_o, held.size() < 2);
    if (bus.alloc_valid_i && held.size() < 2) begin
      held.push_back(fl_q.pop_front());
    end else if (bus.data_valid_i && held.size() >= 2) begin
      b    = blk_q.pop_front();
      addr = held.pop_front();
      foot = '0;
      if (!b.last) foot[AW-1:0] = held[0];
      foot[15] = b.last;
      wr_q.push_back('{addr, {b.data[BB-1:16], foot}});
      if (!in_pkt) begin
        p_head = addr;
        p_len  = 1;
      end else begin
        p_len++;
      end
      in_pkt = !b.last;
      if (b.last) done_q.push_back('{p_head, p_len});
    end
  endtask

  task automatic run(input int max_cycles);
    int n = 0;
    while (blk_q.size() > 0 && n < max_cycles) begin
      step();
      n++;
    end
    check("timeout_blocks_left", blk_q.size(), 0);
    repeat (3) step();
  endtask

  task automatic send_pkt(input int nblk, input logic end_last);
    for (int i = 0; i < nblk; i++) blk_q.push_back('{rnd_block(), end_last && (i == nblk - 1)});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.alloc_valid_i = 1'b0;
    bus.data_valid_i  = 1'b0;
    bus.data_end_i    = 1'b0;
    held.delete();
    fl_q.delete();
    blk_q.delete();
    in_pkt    = 1'b0;
    last_head = '0;
    last_len  = 0;
    #3;
    check("rst_we", bus.mem_we_o, 1'b0);
    check("rst_done", bus.pkt_done_o, 1'b0);
    check("rst_waddr", bus.mem_waddr_o, '0);
    check("rst_wdata", bus.mem_wdata_o, '0);
    check("rst_head", bus.pkt_head_o, '0);
    check("rst_len", bus.pkt_len_o, '0);
    check("rst_data_ready", bus.data_ready_o, 1'b0);
    check("rst_alloc_ready", bus.alloc_ready_o, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bus.alloc_valid_i = 1'b0;
    bus.alloc_idx_i   = '0;
    bus.data_valid_i  = 1'b0;
    bus.data_i        = '0;
    bus.data_end_i    = 1'b0;
    alloc_on = 1'b1;
    in_pkt   = 1'b0;
    p_head   = '0;
    p_len    = 0;
    do_reset();

    // Single-block packet into 5, then the carried index 9 heads the next packet.
    fl_q = '{12'd5, 12'd9};
    send_pkt(1, 1'b1);
    run(50);
    fl_q = '{12'd4};
    send_pkt(1, 1'b1);
    run(50);

    do_reset();
    fl_q = '{12'd3, 12'd7, 12'd11, 12'd2};
    send_pkt(3, 1'b1);
    run(100);

    // Free-list stalls for 10 cycles mid-packet.
    for (int i = 20; i < 26; i++) fl_q.push_back(AW'(i));
    send_pkt(4, 1'b1);
    repeat (6) step();
    alloc_on = 1'b0;
    repeat (10) step();
    alloc_on = 1'b1;
    run(100);

    // Five blocks: the LEN_W=2 instance saturates at 3.
    for (int i = 30; i < 37; i++) fl_q.push_back(AW'(i));
    send_pkt(5, 1'b1);
    run(100);

    // Reset after two blocks of a four-block packet.
    for (int i = 40; i < 45; i++) fl_q.push_back(AW'(i));
    send_pkt(2, 1'b0);
    run(100);
    do_reset();
    fl_q = '{12'd50, 12'd51, 12'd52};
    send_pkt(2, 1'b1);
    run(100);

    check("wr_q_drained", wr_q.size(), 0);
    check("done_q_drained", done_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/memory_write_ctrl.md
MEMORY_WRITE_CTRL -- requirements
Module: memory_write_ctrl

Interface
REQ-001 SHALL take parameter ADDR_W, default 12, block index width (from mem_pkg).
REQ-002 SHALL take parameter BLOCK_BITS, default 512, memory block width (from mem_pkg).
REQ-003 SHALL take parameter LEN_W, default 8, packet block-count width.
REQ-004 SHALL have one clock and an asynchronous, active-low reset.
REQ-005 clk  input  1  clock; all state on rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 data_i  input  BLOCK_BITS  ingress block; bits [15:0] ignored (footer slot).
REQ-008 data_valid_i  input  1  data_i/data_end_i valid.
REQ-009 data_end_i  input  1  block is last of packet.
REQ-010 data_ready_o  output  1  block accepted when data_valid_i && data_ready_o.
REQ-011 alloc_valid_i  input  1  free-list offers alloc_idx_i.
REQ-012 alloc_idx_i  input  ADDR_W  free block index.
REQ-013 alloc_ready_o  output  1  index taken when alloc_valid_i && alloc_ready_o.
REQ-014 mem_we_o  output  1  memory write strobe.
REQ-015 mem_waddr_o  output  ADDR_W  write index.
REQ-016 mem_wdata_o  output  BLOCK_BITS  {payload [BLOCK_BITS-1:16], footer_t [15:0]}.
REQ-017 pkt_done_o  output  1  one-cycle pulse: packet fully written.
REQ-018 pkt_head_o  output  ADDR_W  first block index of completed packet (read-side start_addr).
REQ-019 pkt_len_o  output  LEN_W  blocks in completed packet.

Function
REQ-020 SHALL hold two index slots, CUR and NXT, each with a valid bit.
REQ-021 alloc_ready_o SHALL equal !(CUR_v && NXT_v), from registered state only.
REQ-022 Alloc transfer SHALL load CUR if !CUR_v, else NXT; one index per cycle.
REQ-023 data_ready_o SHALL equal CUR_v && NXT_v, from registered state only (no comb path from inputs).
REQ-024 On block accept SHALL register, for the next cycle: mem_we_o=1, mem_waddr_o=CUR, mem_wdata_o payload=data_i[BLOCK_BITS-1:16].
REQ-025 Footer of a non-end block SHALL be next_idx=NXT, eop=0, rsvd=0.
REQ-026 Footer of an end block SHALL be next_idx=0, eop=1, rsvd=0.
REQ-027 On any accept SHALL set CUR<=NXT, NXT_v<=0 (unused NXT carries to next packet; no index leaked).
REQ-028 Write latency SHALL be exactly 1 cycle accept-to-mem_we_o; mem_we_o=0 in cycles without a preceding accept.
REQ-029 FSM states IDLE, IN_PKT; reset to IDLE.
REQ-030 IDLE + accept, end=0: latch head=CUR, len=1, go IN_PKT.
REQ-031 IDLE + accept, end=1: single-block packet; head=CUR, len=1; stay IDLE.
REQ-032 IN_PKT + accept: len+1, saturating at 2^LEN_W-1; end=1 returns to IDLE.
REQ-033 pkt_done_o SHALL pulse in the same cycle as the end-block mem_we_o, with pkt_head_o/pkt_len_o valid that cycle; held stable otherwise.
REQ-034 Back-to-back accepts SHALL be impossible (ready drops until NXT refilled); max rate one block per two cycles with a free-list offering every cycle.
REQ-035 data_valid_i without ready SHALL have no effect; sender holds data.

Reset
REQ-036 Reset SHALL clear CUR_v, NXT_v, FSM=IDLE, mem_we_o=0, pkt_done_o=0, mem_waddr_o=0, mem_wdata_o=0, pkt_head_o=0, pkt_len_o=0.
REQ-037 Reset mid-packet SHALL discard partial packet and held indices with no pkt_done_o; free-list recovery belongs to its own reset.
REQ-038 Outputs SHALL be valid first edge after rst_n deassert; data_ready_o=0 and alloc_ready_o=1 then.

Verification
REQ-039 Alloc 5 then 9; 1-block packet, end=1 -> write addr 5, footer {next=0,eop=1}; pkt_done head=5 len=1; CUR=9.
REQ-040 Alloc 3,7,11,2; 3-block packet -> writes 3{next=7}, 7{next=11}, 11{eop=1,next=0}; done head=3 len=3.
REQ-041 data_i low 16 bits=0xFFFF -> mem_wdata_o[15:0] carries footer only, rsvd=0.
REQ-042 alloc_valid_i stalled 10 cycles mid-packet -> data_ready_o=0, no writes, resumes correctly.
REQ-043 LEN_W=2, 5-block packet -> pkt_len_o=3 (saturated).
REQ-044 rst_n low after 2nd block of 4 -> no pkt_done_o; next packet head = first index allocated after reset.
